// File: rtl/alu_result_stage_if.sv
// Issue, ALU-result, redirect, writeback and counter signals of the ALU result stage.
interface alu_result_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [1:0]            issue_kind_i;
  logic [4:0]            issue_rd_i;
  logic [ADDR_WIDTH-1:0] issue_pc_i;
  logic [ADDR_WIDTH-1:0] issue_target_i;
  logic [DATA_WIDTH-1:0] alu_res_i;
  logic                  alu_zero_i;
  logic                  redirect_valid_o;
  logic [ADDR_WIDTH-1:0] redirect_pc_o;
  logic                  wb_valid_o;
  logic                  wb_ready_i;
  logic [4:0]            wb_rd_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [CNT_WIDTH-1:0]  br_count_o;
  logic [CNT_WIDTH-1:0]  br_taken_count_o;

  modport master (
    output issue_valid_i, issue_kind_i, issue_rd_i, issue_pc_i, issue_target_i,
           alu_res_i, alu_zero_i, wb_ready_i,
    input  issue_ready_o, redirect_valid_o, redirect_pc_o, wb_valid_o,
           wb_rd_o, wb_data_o, br_count_o, br_taken_count_o
  );

  modport slave (
    input  issue_valid_i, issue_kind_i, issue_rd_i, issue_pc_i, issue_target_i,
           alu_res_i, alu_zero_i, wb_ready_i,
    output issue_ready_o, redirect_valid_o, redirect_pc_o, wb_valid_o,
           wb_rd_o, wb_data_o, br_count_o, br_taken_count_o
  );
endinterface

// File: rtl/alu_result_stage.sv
// Aligns issue metadata with the registered salu result, resolves branches/jumps
// and buffers register writebacks in a small credit-managed FIFO.
module alu_result_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WB_DEPTH   = 3,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);
  localparam int unsigned PTR_WIDTH = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned OCC_WIDTH = $clog2(WB_DEPTH + 1);
  localparam int unsigned SUM_WIDTH = OCC_WIDTH + 1;
  localparam logic [1:0]  KIND_ALU  = 2'b00;
  localparam logic [1:0]  KIND_BR   = 2'b01;
  localparam logic [1:0]  KIND_JAL  = 2'b10;

  typedef struct packed {
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  logic                  s1_valid;
  logic [1:0]            s1_kind;
  logic [4:0]            s1_rd;
  logic [ADDR_WIDTH-1:0] s1_pc;
  logic [ADDR_WIDTH-1:0] s1_target;

  wb_entry_t             mem [WB_DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [OCC_WIDTH-1:0]  occ;
  wb_entry_t             head;
  logic [ADDR_WIDTH-1:0] redirect_pc_q;
  logic [CNT_WIDTH-1:0]  br_cnt;
  logic [CNT_WIDTH-1:0]  br_taken_cnt;

  logic                  taken;
  logic                  ready;
  logic                  fire;
  logic                  push;
  logic                  pop;
  wb_entry_t             push_entry;
  logic [OCC_WIDTH-1:0]  occ_after_pop;
  logic [OCC_WIDTH-1:0]  occ_next;
  logic [PTR_WIDTH-1:0]  rd_ptr_next;
  logic [PTR_WIDTH-1:0]  wr_ptr_next;
  wb_entry_t             head_next;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(WB_DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Resolution, credit check and FIFO next-state.
  always_comb begin
    taken = s1_valid && (((s1_kind == KIND_BR) && bus.alu_zero_i) || (s1_kind == KIND_JAL));
    // Credit counts the in-flight s1 slot; a same-cycle pop is deliberately ignored.
    ready = !taken && ((SUM_WIDTH'(occ) + SUM_WIDTH'(s1_valid)) < SUM_WIDTH'(WB_DEPTH));
    fire  = bus.issue_valid_i && ready;

    push          = s1_valid && (s1_rd != 5'd0) && ((s1_kind == KIND_ALU) || (s1_kind == KIND_JAL));
    push_entry.rd = s1_rd;
    push_entry.data = (s1_kind == KIND_JAL) ? DATA_WIDTH'(s1_pc + ADDR_WIDTH'(4)) : bus.alu_res_i;
    pop           = (occ != '0) && bus.wb_ready_i;

    occ_after_pop = occ - OCC_WIDTH'(pop);
    occ_next      = occ_after_pop + OCC_WIDTH'(push);
    rd_ptr_next   = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_next   = push ? ptr_inc(wr_ptr) : wr_ptr;

    // Head is registered; it holds its last value once the FIFO drains.
    head_next = head;
    if (occ_next != '0) begin
      if (push && (occ_after_pop == '0)) head_next = push_entry;
      else                               head_next = mem[rd_ptr_next];
    end
  end

  // Issue metadata stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_kind   <= 2'b00;
      s1_rd     <= 5'd0;
      s1_pc     <= '0;
      s1_target <= '0;
    end else begin
      s1_valid <= fire;
      if (fire) begin
        s1_kind   <= bus.issue_kind_i;
        s1_rd     <= bus.issue_rd_i;
        s1_pc     <= bus.issue_pc_i;
        s1_target <= bus.issue_target_i;
      end
    end
  end

  // FIFO control, head, redirect hold and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occ           <= '0;
      head          <= '0;
      redirect_pc_q <= '0;
      br_cnt        <= '0;
      br_taken_cnt  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      occ    <= occ_next;
      head   <= head_next;
      if (taken) redirect_pc_q <= s1_target;
      if (s1_valid && ((s1_kind == KIND_BR) || (s1_kind == KIND_JAL)))
        br_cnt <= br_cnt + CNT_WIDTH'(1);
      if (taken) br_taken_cnt <= br_taken_cnt + CNT_WIDTH'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign bus.issue_ready_o    = ready;
  assign bus.redirect_valid_o = taken;
  assign bus.redirect_pc_o    = taken ? s1_target : redirect_pc_q;
  assign bus.wb_valid_o       = (occ != '0);
  assign bus.wb_rd_o          = head.rd;
  assign bus.wb_data_o        = head.data;
  assign bus.br_count_o       = br_cnt;
  assign bus.br_taken_count_o = br_taken_cnt;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (occ == OCC_WIDTH'(WB_DEPTH))))
    else $error("writeback fifo overflow push");
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned DEPTH = 3;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  logic clk;
  logic rst_n;
  alu_result_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(32)) bus ();

  alu_result_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WB_DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state: the instruction whose ALU result is due this cycle, plus a writeback queue.
  bit          m_pend;
  bit [1:0]    m_kind;
  bit [4:0]    m_rd;
  bit [AW-1:0] m_pc;
  bit [AW-1:0] m_tgt;
  wb_t         q[$];
  wb_t         last_head;
  bit [AW-1:0] last_redir;
  bit [31:0]   m_br;
  bit [31:0]   m_tk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_kind = 0; m_rd = 0; m_pc = 0; m_tgt = 0;
    q.delete();
    last_head = '0; last_redir = '0; m_br = 0; m_tk = 0;
  endtask

  // One clock: drive at negedge, compare at negedge+1, then advance the model to the next edge.
  task automatic step(input bit v, input bit [1:0] k, input bit [4:0] r,
                      input bit [AW-1:0] pc, input bit [AW-1:0] tgt,
                      input bit z, input bit wbr);
    bit  tk;
    bit  rdy;
    bit  fire;
    bit  wants_wb;
    wb_t e;
    @(negedge clk);
    bus.issue_valid_i  = v;
    bus.issue_kind_i   = k;
    bus.issue_rd_i     = r;
    bus.issue_pc_i     = pc;
    bus.issue_target_i = tgt;
    bus.alu_zero_i     = z;
    bus.alu_res_i      = $urandom;
    bus.wb_ready_i     = wbr;
    #1;
    tk  = m_pend && ((m_kind == 2'b01 && z) || m_kind == 2'b10);
    rdy = !tk && (q.size() + int'(m_pend) < DEPTH);
    check("issue_ready", bus.issue_ready_o, rdy);
    check("redirect_valid", bus.redirect_valid_o, tk);
    check("redirect_pc", bus.redirect_pc_o, tk ? m_tgt : last_redir);
    check("wb_valid", bus.wb_valid_o, q.size() != 0);
    check("wb_rd", bus.wb_rd_o, last_head.rd);
    check("wb_data", bus.wb_data_o, last_head.data);
    check("br_count", bus.br_count_o, m_br);
    check("br_taken_count", bus.br_taken_count_o, m_tk);

    fire = v && rdy;
    wants_wb = m_pend && m_rd != 0 && (m_kind == 2'b00 || m_kind == 2'b10);
    if (q.size() != 0 && wbr) void'(q.pop_front());
    if (wants_wb) begin
      e.rd   = m_rd;
      e.data = (m_kind == 2'b10) ? DW'(m_pc + 32'd4) : bus.alu_res_i;
      q.push_back(e);
    end
    if (q.size() != 0) last_head = q[0];
    if (m_pend && (m_kind == 2'b01 || m_kind == 2'b10)) m_br++;
    if (tk) begin
      m_tk++;
      last_redir = m_tgt;
    end
    m_pend = fire;
    if (fire) begin
      m_kind = k; m_rd = r; m_pc = pc; m_tgt = tgt;
    end
  endtask

  task automatic idle(input int n, input bit wbr);
    for (int i = 0; i < n; i++) step(0, 2'b11, 5'd0, '0, '0, 1'b0, wbr);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    bus.issue_valid_i = 0; bus.issue_kind_i = 0; bus.issue_rd_i = 0;
    bus.issue_pc_i = 0; bus.issue_target_i = 0; bus.alu_res_i = 0;
    bus.alu_zero_i = 0; bus.wb_ready_i = 0;
    repeat (2) @(negedge clk);
    check("rst_issue_ready", bus.issue_ready_o, 1'b1);
    check("rst_redirect_valid", bus.redirect_valid_o, 1'b0);
    check("rst_redirect_pc", bus.redirect_pc_o, 0);
    check("rst_wb_valid", bus.wb_valid_o, 1'b0);
    check("rst_wb_rd", bus.wb_rd_o, 0);
    check("rst_wb_data", bus.wb_data_o, 0);
    rst_n = 1'b1;

    // Back-to-back ALU writebacks.
    for (int i = 1; i <= 4; i++) step(1, 2'b00, 5'(i), 32'h10 + 32'(4 * i), '0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Back-pressure, then drain.
    for (int i = 1; i <= 6; i++) step(1, 2'b00, 5'(i + 8), '0, '0, 1'b0, 1'b0);
    check("bp_occupancy", q.size(), DEPTH);
    idle(6, 1'b1);

    // Conditional branch taken, then not taken.
    step(1, 2'b01, 5'd3, 32'h100, 32'h80, 1'b0, 1'b1);
    step(0, 2'b11, 5'd0, '0, '0, 1'b1, 1'b1);
    check("br_taken_redirect", bus.redirect_pc_o, 32'h80);
    step(0, 2'b11, 5'd0, '0, '0, 1'b0, 1'b1);
    check("br_count_after_taken", bus.br_count_o, 1);
    check("br_taken_after_taken", bus.br_taken_count_o, 1);
    step(1, 2'b01, 5'd3, 32'h100, 32'h80, 1'b0, 1'b1);
    step(0, 2'b11, 5'd0, '0, '0, 1'b0, 1'b1);
    step(0, 2'b11, 5'd0, '0, '0, 1'b0, 1'b1);
    check("br_count_after_nt", bus.br_count_o, 2);
    check("br_taken_after_nt", bus.br_taken_count_o, 1);

    // Jump-and-link with pc+4 wrap, then with rd=0.
    step(1, 2'b10, 5'd1, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1);
    step(0, 2'b11, 5'd0, '0, '0, 1'b0, 1'b1);
    step(0, 2'b11, 5'd0, '0, '0, 1'b0, 1'b1);
    check("jal_wb_valid", bus.wb_valid_o, 1'b1);
    check("jal_wb_rd", bus.wb_rd_o, 1);
    check("jal_wb_data", bus.wb_data_o, 0);
    step(1, 2'b10, 5'd0, 32'h200, 32'h44, 1'b0, 1'b1);
    idle(3, 1'b1);

    // rd=0 filter and no-writeback kind.
    step(1, 2'b00, 5'd0, '0, '0, 1'b0, 1'b1);
    step(1, 2'b11, 5'd5, '0, '0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic with phases of heavy back-pressure.
    for (int i = 0; i < 800; i++) begin
      bit wbr;
      if ((i / 100) % 2 == 1) wbr = ($urandom_range(0, 3) == 0);
      else                    wbr = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
           {$urandom, 2'b00} , $urandom, 1'($urandom_range(0, 1)), wbr);
    end

    // Reset mid-operation with buffered entries and a valid s1.
    for (int i = 1; i <= 3; i++) step(1, 2'b00, 5'(i + 20), '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    bus.issue_valid_i = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_wb_valid", bus.wb_valid_o, 1'b0);
    check("mid_rst_redirect_valid", bus.redirect_valid_o, 1'b0);
    check("mid_rst_br_count", bus.br_count_o, 0);
    check("mid_rst_br_taken", bus.br_taken_count_o, 0);
    check("mid_rst_issue_ready", bus.issue_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
